// File: rtl/rob_n.sv
// Reorder buffer: dispatches up to DISP_W entries per cycle in order, marks them done from
// CDB_W ports, retires up to RET_W per cycle in order, and flushes on a mispredicted branch.
module rob_n #(
   parameter int DEPTH  = 64,
   parameter int IDX_W  = 6,
   parameter int TAG_W  = 7,
   parameter int DISP_W = 2,
   parameter int CDB_W  = 4,
   parameter int RET_W  = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DISP_W-1:0]       disp_valid,
   input  logic [DISP_W*TAG_W-1:0] disp_tag,
   input  logic [DISP_W*TAG_W-1:0] disp_told,
   input  logic [DISP_W*5-1:0]     disp_ar,
   output logic                    disp_ready,
   output logic [DISP_W*IDX_W-1:0] disp_idx,
   input  logic [CDB_W-1:0]        cdb_valid,
   input  logic [CDB_W*IDX_W-1:0]  cdb_idx,
   input  logic [CDB_W-1:0]        cdb_mispred,
   input  logic [CDB_W*64-1:0]     cdb_target,
   output logic [RET_W-1:0]        retire_valid,
   output logic [RET_W*TAG_W-1:0]  retire_tag,
   output logic [RET_W*TAG_W-1:0]  retire_told,
   output logic [RET_W*5-1:0]      retire_ar,
   output logic                    flush,
   output logic [63:0]             flush_pc,
   output logic [IDX_W:0]          count,
   output logic                    empty,
   output logic                    full
);

   localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0] DISP_C  = (IDX_W+1)'(DISP_W);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] done_q;
   logic [DEPTH-1:0] mispred_q;
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [TAG_W-1:0] told_q   [DEPTH];
   logic [4:0]       ar_q     [DEPTH];
   logic [63:0]      target_q [DEPTH];

   logic [IDX_W-1:0] head_q;
   logic [IDX_W-1:0] tail_q;
   logic [IDX_W:0]   count_q;

   logic [IDX_W:0]   disp_cnt;
   logic [IDX_W:0]   disp_eff;
   logic             disp_fire;
   logic [IDX_W:0]   ret_cnt;
   logic [IDX_W-1:0] head_next;

   assign count      = count_q;
   assign empty      = (count_q == '0);
   assign full       = (count_q == DEPTH_C);
   assign disp_ready = ((DEPTH_C - count_q) >= DISP_C);
   assign disp_fire  = disp_ready && !flush;
   assign disp_eff   = disp_fire ? disp_cnt : '0;
   assign head_next  = head_q + ret_cnt[IDX_W-1:0];

   // Slot indices follow the tail; valid slots are contiguous so the popcount is the advance.
   always_comb begin
      disp_cnt = '0;
      disp_idx = '0;
      for (int i = 0; i < DISP_W; i++) begin
         disp_idx[i*IDX_W +: IDX_W] = tail_q + IDX_W'(i);
         if (disp_valid[i]) begin
            disp_cnt = disp_cnt + (IDX_W+1)'(1);
         end
      end
   end

   // In-order retire window; the chain breaks at the first not-ready entry or after a mispredict.
   always_comb begin
      logic             chain;
      logic [IDX_W-1:0] ridx;
      chain        = 1'b1;
      ridx         = head_q;
      retire_valid = '0;
      retire_tag   = '0;
      retire_told  = '0;
      retire_ar    = '0;
      flush        = 1'b0;
      flush_pc     = '0;
      ret_cnt      = '0;
      for (int i = 0; i < RET_W; i++) begin
         ridx = head_q + IDX_W'(i);
         retire_tag[i*TAG_W +: TAG_W]  = tag_q[ridx];
         retire_told[i*TAG_W +: TAG_W] = told_q[ridx];
         retire_ar[i*5 +: 5]           = ar_q[ridx];
         if (chain && valid_q[ridx] && done_q[ridx]) begin
            retire_valid[i] = 1'b1;
            ret_cnt         = ret_cnt + (IDX_W+1)'(1);
            if (mispred_q[ridx]) begin
               flush    = 1'b1;
               flush_pc = target_q[ridx];
               chain    = 1'b0;
            end
         end else begin
            chain = 1'b0;
         end
      end
   end

   // Control state: completion, then retire clears, then dispatch writes (later writes win).
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q   <= '0;
         done_q    <= '0;
         mispred_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         head_q <= head_next;
         if (flush) begin
            valid_q   <= '0;
            done_q    <= '0;
            mispred_q <= '0;
            tail_q    <= head_next;
            count_q   <= '0;
         end else begin
            for (int p = CDB_W-1; p >= 0; p--) begin
               if (cdb_valid[p] && valid_q[cdb_idx[p*IDX_W +: IDX_W]]) begin
                  done_q[cdb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
                  if (cdb_mispred[p]) begin
                     mispred_q[cdb_idx[p*IDX_W +: IDX_W]] <= 1'b1;
                  end
               end
            end
            for (int i = 0; i < RET_W; i++) begin
               if (retire_valid[i]) begin
                  valid_q[head_q + IDX_W'(i)]   <= 1'b0;
                  done_q[head_q + IDX_W'(i)]    <= 1'b0;
                  mispred_q[head_q + IDX_W'(i)] <= 1'b0;
               end
            end
            if (disp_fire) begin
               for (int i = 0; i < DISP_W; i++) begin
                  if (disp_valid[i]) begin
                     valid_q[tail_q + IDX_W'(i)]   <= 1'b1;
                     done_q[tail_q + IDX_W'(i)]    <= 1'b0;
                     mispred_q[tail_q + IDX_W'(i)] <= 1'b0;
                  end
               end
            end
            tail_q  <= tail_q + disp_eff[IDX_W-1:0];
            count_q <= count_q + disp_eff - ret_cnt;
         end
      end
   end

   // Payload storage needs no reset; the descending port loop lets the lowest port's target win.
   always_ff @(posedge clock) begin
      if (!reset && !flush) begin
         for (int p = CDB_W-1; p >= 0; p--) begin
            if (cdb_valid[p] && cdb_mispred[p] && valid_q[cdb_idx[p*IDX_W +: IDX_W]]) begin
               target_q[cdb_idx[p*IDX_W +: IDX_W]] <= cdb_target[p*64 +: 64];
            end
         end
         if (disp_fire) begin
            for (int i = 0; i < DISP_W; i++) begin
               if (disp_valid[i]) begin
                  tag_q[tail_q + IDX_W'(i)]  <= disp_tag[i*TAG_W +: TAG_W];
                  told_q[tail_q + IDX_W'(i)] <= disp_told[i*TAG_W +: TAG_W];
                  ar_q[tail_q + IDX_W'(i)]   <= disp_ar[i*5 +: 5];
               end
            end
         end
      end
   end

endmodule

// File: doc/rob_n.md
# rob_n

Parametrised reorder buffer for the out-of-order core, sitting between dispatch (free list / map table / RS) and retirement (architectural map / free list). It accepts up to DISP_W instructions per cycle in program order. It marks entries complete from CDB_W completion ports, addressed by ROB index. It retires up to RET_W entries per cycle in order, and recovers from a mispredicted branch by flushing every younger entry at retirement.

## Interface
Parameters:
- DEPTH, 64, number of entries; power of two
- IDX_W, 6, log2(DEPTH)
- TAG_W, 7, physical register tag width
- DISP_W, 2, dispatch slots per cycle
- CDB_W, 4, completion ports
- RET_W, 2, retire slots per cycle

Ports (packed vectors; slot/port i occupies bits [i*W +: W]):
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- disp_valid  in  DISP_W  dispatch request per slot; must be contiguous from bit 0
- disp_tag  in  DISP_W*TAG_W  new physical dest tag (T)
- disp_told  in  DISP_W*TAG_W  previous mapping (Told)
- disp_ar  in  DISP_W*5  architectural dest; 31 = no dest
- disp_ready  out  1  free slots >= DISP_W
- disp_idx  out  DISP_W*IDX_W  ROB index assigned to each slot (tail+i)
- cdb_valid  in  CDB_W  completion strobe per port
- cdb_idx  in  CDB_W*IDX_W  ROB index completing
- cdb_mispred  in  CDB_W  completing branch was mispredicted
- cdb_target  in  CDB_W*64  correct PC of a mispredicted branch
- retire_valid  out  RET_W  thermometer; slot i retiring this cycle
- retire_tag, retire_told  out  RET_W*TAG_W  T / Told of retiring entries
- retire_ar  out  RET_W*5  architectural dest of retiring entries
- flush  out  1  mispredicted branch retiring this cycle
- flush_pc  out  64  redirect PC, valid while flush=1
- count  out  IDX_W+1  occupied entries
- empty, full  out  1  count==0 / count==DEPTH

## Operation
- Per-entry state: valid, done, mispred, tag, told, ar, target. Head and tail pointers are IDX_W bits wide and wrap modulo DEPTH naturally. count is registered.
- Dispatch: if disp_ready && !flush, slots with disp_valid write entry tail+i (valid=1, done=0, mispred=0), and tail advances by popcount(disp_valid). Otherwise the request is ignored and tail holds. disp_ready uses the registered count only, so slots freed by a same-cycle retire do not count.
- Complete: for each port with cdb_valid, and only if entry cdb_idx is valid, set done=1. If cdb_mispred is also set, set mispred=1 and latch target. Writes from several ports to the same index OR together; target comes from the lowest-numbered port. Completion to an invalid entry is dropped.
- Retire (combinational from registered state):
  - Slot i retires if entries head..head+i are all valid and done.
  - Retirement stops after the first entry with mispred=1.
  - If that entry retires: flush=1 and flush_pc=its target.
  - At the edge, head advances by the retire count and valid clears for retired entries.
- Flush edge: all entries are invalidated, tail is set to the new head, and count=0. Dispatch and completions arriving in the flush cycle are discarded.
- count_next = count + dispatched − retired. It is never above DEPTH or below 0 by construction.

## Timing
- Reset: head=tail=0, count=0, all valid/done/mispred=0. Resulting outputs: empty=1, full=0, disp_ready=1, retire_valid=0, flush=0, flush_pc=0, disp_idx slot i = i. Reset mid-operation discards all contents with no retire.
- Dispatch: entry is written at edge t. disp_idx is valid combinationally in the same cycle as disp_valid.
- Complete at edge t → earliest retire_valid in cycle t+1 → head advances at edge t+1.
- Minimum dispatch→retire latency is 2 edges.
- Simultaneous dispatch and retire at full: retire proceeds. Dispatch is blocked because disp_ready=0.
- Wrap: indices DEPTH-1 → 0 without gaps for dispatch, retire and disp_idx.

## Test plan
- Reset, then dispatch 2 (tags 0x20,0x21; told 0x01,0x02; ar 3,4) → disp_idx 0,1; next cycle count=2, empty=0.
- Complete idx1 then idx0 in the following cycle → no retire until idx0 is done. Then retire_valid=2'b11, retire_tag 0x20/0x21, retire_told 0x01/0x02; count=0 the next cycle.
- Dispatch DEPTH entries (2/cycle) → full=1, disp_ready=0; a further disp_valid is ignored and tail is unchanged. Complete and retire 2 → disp_ready=1 the next cycle.
- Fill to tail=62, retire to head=62, dispatch 2 → disp_idx 62,63; next dispatch gets 0,1; retire order is 62,63,0,1.
- Entries A,B,C with B mispredicted (target 0x1000), all done → cycle 1: retire_valid=2'b11 (A,B), flush=1, flush_pc=0x1000. Next: C is gone, count=0, tail=head.
- Two CDB ports hit the same index while another port hits an invalid index → entry done once, no spurious valid entry; assert reset mid-fill → empty=1 next cycle.
